sa_job_sequencer: RTL
=====================

// Module: sa_job_sequencer
// PURPOSE
//  Sequences one 4x4 matrix job through the 4x4 weight-stationary systolic PE array.
//  - Latches an activation matrix A and a weight matrix W from the host; holds W on the array weight bus.
//  - Streams A into in_left with per-row skew; drives in_up with zero partial sums.
//  - De-skews out_down into result matrix C = A x W; returns C over a valid/ready handshake.
// PARAMETERS
//  WIDTH       16  signed data width of A, W, C and all array links
//  PIPE_DEPTH  4   cycles from a row-0 in_left sample to its column-0 sum on out_down (one per PE row)
//  W_SETTLE    1   cycles W is held on the array before the first activation is fed (>=1)
// PORTS
//  clk        in   1             clock
//  rst        in   1             asynchronous, active-low reset
//  start      in   1             host job request; accepted when start & start_ready
//  start_ready out 1             high only in IDLE
//  a_in       in   [4][4]xWIDTH  activation matrix A[k][i], sampled on accept
//  w_in       in   [4][4]xWIDTH  weight matrix W[i][j], sampled on accept
//  arr_weights out [4][4]xWIDTH  to array weights; the latched W
//  arr_left   out  [4]xWIDTH     to array in_left
//  arr_up     out  [4]xWIDTH     to array in_up; constant 0
//  arr_down   in   [4]xWIDTH     from array out_down
//  res_valid  out  1             C valid; held until res_ready
//  res_ready  in   1             host accepts C
//  res_c      out  [4][4]xWIDTH  result C[k][j]
//  busy       out  1             high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; cnt=0; all registered outputs, A/W/C latches = 0.
//  - start_ready=1; res_valid=0; busy=0.
//  FSM IDLE->LOAD_W->FEED->DONE->IDLE:
//  - IDLE: on start, latch A and W; cnt=0; go to LOAD_W. Otherwise start is ignored.
//  - LOAD_W: arr_weights=W. After W_SETTLE cycles: cnt=0, go to FEED.
//  - FEED: cnt counts 0..LAST, LAST = 3+3+PIPE_DEPTH (=10 at default).
//    - arr_left[i] = A[cnt-i][i] when 0<=cnt-i<=3, else 0. Registered: value presented in cycle cnt.
//    - Capture: C[k][j] <= arr_down[j] in the cycle where cnt == k+j+PIPE_DEPTH, for k,j in 0..3.
//    - At cnt==LAST: capture is done; go to DONE.
//  - DONE: res_valid=1, res_c=C, held stable. On res_ready, go to IDLE.
//    - start_ready rises the following cycle, so start is never accepted in the same cycle as res_ready.
//  Outputs held outside active phases:
//  - arr_weights keeps the last W in every state; cleared only by reset.
//  - arr_left=0 outside FEED slots; arr_up=0 always, so no array flush is needed between jobs.
//  Arithmetic: no arithmetic in this block; C is WIDTH bits, taken as the array produced it.
//    Wrap and overflow are owned by the PE.
//  Latency: accept -> res_valid = 1 + W_SETTLE + LAST + 1 cycles (13 at defaults).
//  Boundary conditions:
//  - start while busy: ignored, no latch change.
//  - res_ready with res_valid=0: ignored.
//  - res_ready held high continuously: completes the job in its first DONE cycle.
//  - rst low mid-job: everything clears immediately; the array sees in_left=0 from then on.
//    The partial job is lost; the host must re-issue it.
// STRUCTURE
//  Package sa_pkg:
//  - N=4.
//  - typedef data_t (logic signed [WIDTH-1:0]).
//  - typedef mat_t (data_t [N][N]) and vec_t (data_t [N]).
//  - seq_state_e {IDLE, LOAD_W, FEED, DONE}.
//  - function feed_last(PIPE_DEPTH).
//  Sub-module sa_skew_feeder: cnt + A in -> skewed arr_left, registered; independently testable.
//  FSM, counter, capture logic and result register stay in sa_job_sequencer.
// TESTING
//  Testbench: sequencer + PE array + golden model C = A x W. Check arr_left against an expected skew table every cycle.
//  1. Identity: W=I, A rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16].
//     -> C==A; res_valid asserts exactly 13 cycles after accept.
//  2. Signed: W all -2, A all 3. -> every C = -24.
//     Also A=0x7FFF, W=2: C matches the PE wrap behaviour, no extra truncation.
//  3. Back-pressure: hold res_ready=0 for 20 cycles. -> res_c stable; start_ready=0; start pulses ignored.
//     Then res_ready=1 -> IDLE next cycle; a new job runs normally.
//  4. Back-to-back jobs: start held high, res_ready held high, two different W.
//     -> second result uses the second W; no residue from job 1 in job 2's C.
//  5. Reset mid-FEED: drop rst at cnt=5.
//     -> all outputs 0 within the same cycle; IDLE after release; a fresh job gives the correct C.
//  6. Skew check: A[k][i]=16*k+i.
//     -> arr_left[i] equals A[cnt-i][i] in window cnt=i..i+3 and 0 outside it.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared sizing, types and state encoding for the 4x4 systolic job sequencer.
package sa_pkg;
   localparam int N     = 4;
   localparam int WIDTH = 16;
   localparam int CNT_W = 6;
   localparam int IDX_W = $clog2(N);

   typedef logic signed [WIDTH-1:0] data_t;
   typedef data_t [N-1:0] vec_t;
   typedef vec_t  [N-1:0] mat_t;

   typedef enum logic [1:0] {IDLE, LOAD_W, FEED, DONE} seq_state_e;

   // Last FEED count: the final (row N-1, column N-1) sum leaves the array here.
   function automatic int feed_last(input int pipe_depth);
      return 2 * (N - 1) + pipe_depth;
   endfunction
endpackage

// File: rtl/sa_skew_feeder.sv
// Skews activation rows onto the array's left edge; one register stage, so it is driven with next-cycle count/enable.
// Row i carries A[cnt-i][i] while 0 <= cnt-i < N, otherwise zero.
module sa_skew_feeder
   import sa_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  mat_t             a_i,
   output vec_t             left_o
);
   vec_t             left_d;
   vec_t             left_q;
   logic [CNT_W-1:0] diag;

   always_comb begin
      left_d = '0;
      diag   = '0;
      for (int i = 0; i < N; i++) begin
         diag = cnt_i - CNT_W'(i);
         if (en_i && (cnt_i >= CNT_W'(i)) && (diag < CNT_W'(N)))
            left_d[i] = a_i[diag[IDX_W-1:0]][i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) left_q <= '0;
      else         left_q <= left_d;
   end

   assign left_o = left_q;
endmodule

// File: rtl/sa_job_sequencer.sv
// Runs one 4x4 job: latch A/W, settle W, stream skewed A, de-skew the column sums into C.
// Result held on res_valid until res_ready; new jobs are refused until the result is taken.
module sa_job_sequencer
   import sa_pkg::*;
#(
   parameter int PIPE_DEPTH = 4,
   parameter int W_SETTLE   = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   output logic start_ready_o,
   input  mat_t a_in_i,
   input  mat_t w_in_i,
   output mat_t arr_weights_o,
   output vec_t arr_left_o,
   output vec_t arr_up_o,
   input  vec_t arr_down_i,
   output logic res_valid_o,
   input  logic res_ready_i,
   output mat_t res_c_o,
   output logic busy_o
);
   localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(feed_last(PIPE_DEPTH));
   localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(W_SETTLE - 1);

   seq_state_e       state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   mat_t             a_d, a_q, w_d, w_q, c_d, c_q;
   logic             feed_d;
   logic             start_ready_q, busy_q, res_valid_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      w_d     = w_q;
      c_d     = c_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = LOAD_W;
               cnt_d   = '0;
               a_d     = a_in_i;
               w_d     = w_in_i;
            end
         end
         LOAD_W: begin
            if (cnt_q == SETTLE_C) begin
               state_d = FEED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FEED: begin
            // Sum for C[k][j] sits on column j exactly k+j+PIPE_DEPTH counts after feeding starts.
            for (int k = 0; k < N; k++)
               for (int j = 0; j < N; j++)
                  if (cnt_q == CNT_W'(k + j + PIPE_DEPTH))
                     c_d[k][j] = arr_down_i[j];
            if (cnt_q == LAST_C) state_d = DONE;
            else                 cnt_d   = cnt_q + CNT_W'(1);
         end
         DONE: begin
            if (res_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      feed_d = (state_d == FEED);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         a_q           <= '0;
         w_q           <= '0;
         c_q           <= '0;
         start_ready_q <= 1'b1;
         busy_q        <= 1'b0;
         res_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         a_q           <= a_d;
         w_q           <= w_d;
         c_q           <= c_d;
         start_ready_q <= (state_d == IDLE);
         busy_q        <= (state_d != IDLE);
         res_valid_q   <= (state_d == DONE);
      end
   end

   sa_skew_feeder u_feeder (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (feed_d),
      .cnt_i  (cnt_d),
      .a_i    (a_q),
      .left_o (arr_left_o)
   );

   assign arr_weights_o = w_q;
   assign arr_up_o      = '0;
   assign start_ready_o = start_ready_q;
   assign busy_o        = busy_q;
   assign res_valid_o   = res_valid_q;
   assign res_c_o       = c_q;
endmodule
